boot_loader: RTL and testbench

Serial boot loader that fills the CPU instruction RAM through its write port (`iaddr_write`/`idata_write`/`i_write`) before execution starts. It contains an 8N1 UART receiver, assembles byte pairs into 16-bit words, and writes them to consecutive addresses from 0. It holds the CPU in reset for the whole load and releases it only after a complete, valid image.

---
 rtl/boot_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_boot_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: UART (8N1) serial boot loader for the CPU instruction RAM.
// Receives "A5, L, L+1 words (low byte first)[, checksum]" and writes the words
// to consecutive addresses from 0, holding the CPU in reset until the image is complete.
// Optional feature macro: BOOT_CHECKSUM_EN (adds a trailing XOR checksum byte).
module boot_loader #(
   parameter int width        = 16,
   parameter int iaddr_width  = 8,
   parameter int clks_per_bit = 104
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx,
   output logic [iaddr_width-1:0] iaddr_write,
   output logic [width-1:0]       idata_write,
   output logic                   i_write,
   output logic                   cpu_reset,
   output logic                   done,
   output logic                   error
);

   localparam int CNT_W = $clog2(clks_per_bit);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clks_per_bit - 1);
   // Start-bit centre check: the idle-detect cycle and the state register already
   // add two cycles after the synchronized edge, so count two fewer than half a bit.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clks_per_bit / 2 - 2);
   localparam logic [7:0]       SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef enum logic [2:0] {
      LD_SYNC, LD_LEN, LD_LO, LD_HI,
`ifdef BOOT_CHECKSUM_EN
      LD_CSUM,
`endif
      LD_RUN, LD_ERR
   } ld_state_t;

   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             rx_valid, rx_ferr;

   ld_state_t              ld_state_q, ld_state_d;
   logic [iaddr_width-1:0] addr_q, addr_d;
   logic [7:0]             wcnt_q, wcnt_d;
   logic [7:0]             len_q, len_d;
   logic [7:0]             lo_q, lo_d;
   logic [7:0]             csum_q, csum_d;
   logic [iaddr_width-1:0] iaddr_q, iaddr_d;
   logic [width-1:0]       idata_q, idata_d;
   logic                   iwr_q, iwr_d;

   // Two-flop synchronizer for rx plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receiver control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
      end
   end

   // Receive shift register (data only, no reset needed).
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   // Receiver next state: start re-check at half bit, data and stop at bit centres.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      rx_valid   = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d      = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               rx_state_d = RX_IDLE;
               rx_valid   = rx_sync_q;
               rx_ferr    = !rx_sync_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Loader control and RAM write-port registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_state_q <= LD_SYNC;
         addr_q     <= '0;
         wcnt_q     <= '0;
         iaddr_q    <= '0;
         idata_q    <= '0;
         iwr_q      <= 1'b0;
      end else begin
         ld_state_q <= ld_state_d;
         addr_q     <= addr_d;
         wcnt_q     <= wcnt_d;
         iaddr_q    <= iaddr_d;
         idata_q    <= idata_d;
         iwr_q      <= iwr_d;
      end
   end

   // Loader data holding registers (length, low byte, running checksum).
   always_ff @(posedge clk) begin
      len_q  <= len_d;
      lo_q   <= lo_d;
      csum_q <= csum_d;
   end

   // Loader next state: consumes one byte per rx_valid; framing errors abort unless running.
   always_comb begin
      ld_state_d = ld_state_q;
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      len_d      = len_q;
      lo_d       = lo_q;
      csum_d     = csum_q;
      iaddr_d    = iaddr_q;
      idata_d    = idata_q;
      iwr_d      = 1'b0;
      if (rx_ferr && ld_state_q != LD_RUN) begin
         ld_state_d = LD_ERR;
      end else if (rx_valid) begin
         case (ld_state_q)
            LD_SYNC, LD_ERR: begin
               if (shift_q == SYNC_BYTE) begin
                  ld_state_d = LD_LEN;
                  addr_d     = '0;
                  wcnt_d     = '0;
                  csum_d     = '0;
               end
            end
            LD_LEN: begin
               len_d      = shift_q;
               csum_d     = csum_q ^ shift_q;
               ld_state_d = LD_LO;
            end
            LD_LO: begin
               lo_d       = shift_q;
               csum_d     = csum_q ^ shift_q;
               ld_state_d = LD_HI;
            end
            LD_HI: begin
               csum_d  = csum_q ^ shift_q;
               iwr_d   = 1'b1;
               iaddr_d = addr_q;
               idata_d = width'({shift_q, lo_q});
               addr_d  = addr_q + 1'b1;
               if (wcnt_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
                  ld_state_d = LD_CSUM;
`else
                  ld_state_d = LD_RUN;
`endif
               end else begin
                  wcnt_d     = wcnt_q + 1'b1;
                  ld_state_d = LD_LO;
               end
            end
`ifdef BOOT_CHECKSUM_EN
            LD_CSUM: ld_state_d = (shift_q == csum_q) ? LD_RUN : LD_ERR;
`endif
            default: ;
         endcase
      end
   end

   assign iaddr_write = iaddr_q;
   assign idata_write = idata_q;
   assign i_write     = iwr_q;
   assign done        = (ld_state_q == LD_RUN);
   assign cpu_reset   = (ld_state_q != LD_RUN);
   assign error       = (ld_state_q == LD_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized self-checking bench for boot_loader.
// A byte-level reference model tracks expected RAM writes and done/error status.
module tb_boot_loader;

   localparam int CPB = 4;
   localparam int AW  = 3;
`ifdef BOOT_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx = 1'b1;
   logic [AW-1:0] iaddr_write;
   logic [15:0]   idata_write;
   logic          i_write, cpu_reset, done, error;

   int checks = 0;
   int failures = 0;

   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   logic [7:0]  pay_q[$];
   logic        prev_iw = 1'b0;

   // Reference model state: 0 hunting for sync, 1 length, 2 low, 3 high, 4 checksum, 5 running.
   int         m_mode = 0;
   bit         m_err = 1'b0;
   int         m_len = 0, m_cnt = 0, m_addr = 0;
   logic [7:0] m_lo = '0, m_csum = '0;

   boot_loader #(.width(16), .iaddr_width(AW), .clks_per_bit(CPB)) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .iaddr_write(iaddr_write), .idata_write(idata_write), .i_write(i_write),
      .cpu_reset(cpu_reset), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Collect every RAM write and make sure each strobe lasts a single cycle.
   always @(negedge clk) begin
      if (i_write) begin
         chk("iw_one_cycle", {31'd0, prev_iw}, 32'd0);
         got_q.push_back((32'(iaddr_write) << 16) | 32'(idata_write));
      end
      prev_iw = i_write;
   end

   task automatic model_reset();
      m_mode = 0; m_err = 1'b0; m_addr = 0; m_cnt = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ferr);
      if (m_mode == 5) return;
      if (ferr) begin
         m_mode = 0; m_err = 1'b1;
         return;
      end
      case (m_mode)
         0: if (b == 8'hA5) begin m_err = 1'b0; m_addr = 0; m_cnt = 0; m_mode = 1; end
         1: begin m_len = int'(b); m_csum = b; m_mode = 2; end
         2: begin m_lo = b; m_csum ^= b; m_mode = 3; end
         3: begin
            m_csum ^= b;
            exp_q.push_back((32'(m_addr) << 16) | {16'd0, b, m_lo});
            m_addr = (m_addr + 1) % (1 << AW);
            if (m_cnt == m_len) m_mode = CSUM_EN ? 4 : 5;
            else begin m_cnt++; m_mode = 2; end
         end
         4: begin
            if (b == m_csum) m_mode = 5;
            else begin m_err = 1'b1; m_mode = 0; end
         end
         default: ;
      endcase
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ferr);
      int idle;
      model_byte(b, ferr);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(!ferr);
      idle = ferr ? 2 : int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) send_bit(1'b1);
   endtask

   // Sends A5, L, the words in pay_q and (if enabled) the checksum; ferr_pos < 0 means no framing error.
   task automatic send_frame(input int ferr_pos, input bit bad_csum);
      logic [7:0] seq[$];
      logic [7:0] len, cs;
      len = 8'(pay_q.size() / 2 - 1);
      cs  = len;
      seq.push_back(8'hA5);
      seq.push_back(len);
      foreach (pay_q[i]) begin
         seq.push_back(pay_q[i]);
         cs ^= pay_q[i];
      end
      if (CSUM_EN) seq.push_back(bad_csum ? (cs ^ 8'h5A) : cs);
      foreach (seq[i]) send_byte(seq[i], i == ferr_pos);
   endtask

   task automatic glitch();
      rx = 1'b0;
      @(posedge clk); #1;
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".iaddr"}, 32'(iaddr_write), 32'd0);
      chk({tag, ".idata"}, 32'(idata_write), 32'd0);
      chk({tag, ".iwr"}, 32'(i_write), 32'd0);
      chk({tag, ".cpu_rst"}, 32'(cpu_reset), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk({tag, ".error"}, 32'(error), 32'd0);
   endtask

   task automatic reset_pulse(input bit check_now);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      if (check_now) check_reset_vals("midrst");
      reset = 1'b0;
      model_reset();
   endtask

   task automatic end_check(input string tag);
      logic [31:0] last;
      repeat (3 * CPB) @(posedge clk);
      #1;
      chk({tag, ".done"}, 32'(done), 32'(m_mode == 5));
      chk({tag, ".cpu_rst"}, 32'(cpu_reset), 32'(m_mode != 5));
      chk({tag, ".error"}, 32'(error), 32'(m_err));
      chk({tag, ".nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, ".wr"}, got_q[i], exp_q[i]);
      last = (exp_q.size() > 0) ? exp_q[$] : 32'd0;
      chk({tag, ".hold"}, (32'(iaddr_write) << 16) | 32'(idata_write), last);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      reset = 1'b0;
      model_reset();

      // Two-word image.
      pay_q = {8'h34, 8'h12, 8'hCD, 8'hAB};
      send_frame(-1, 1'b0);
      end_check("two_words");

      // Leading junk is ignored, then a one-word image.
      reset_pulse(1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'h7E, 1'b0);
      glitch();
      pay_q = {8'hEF, 8'hBE};
      send_frame(-1, 1'b0);
      end_check("junk_then_load");

      // Traffic while running is ignored.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h55, 1'b0);
      end_check("run_ignores");

`ifdef BOOT_CHECKSUM_EN
      // Bad checksum, then recovery with a valid frame.
      reset_pulse(1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h00, 1'b0);
      end_check("bad_csum");
      pay_q = {8'h78, 8'h56};
      send_frame(-1, 1'b0);
      end_check("csum_recover");
`endif

      // Framing error on the low byte, then recovery.
      reset_pulse(1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h34, 1'b1);
      end_check("ferr");
      pay_q = {8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(-1, 1'b0);
      end_check("ferr_recover");

      // Reset right after the length byte, then a fresh load from address 0.
      reset_pulse(1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h03, 1'b0);
      repeat (2 * CPB) @(posedge clk);
      #1;
      reset_pulse(1'b1);
      pay_q = {8'hAA, 8'h55, 8'h11, 8'h99};
      send_frame(-1, 1'b0);
      end_check("after_midrst");

      // Randomized images, including address wrap, junk, glitches and errors.
      for (int it = 0; it < 14; it++) begin
         int nj, nw, fpos;
         bit bad;
         reset_pulse(1'b0);
         nj = int'($urandom_range(0, 3));
         for (int j = 0; j < nj; j++) begin
            logic [7:0] g;
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1'b0);
         end
         if ($urandom_range(0, 2) == 0) glitch();
         nw = int'($urandom_range(1, 11));
         pay_q.delete();
         for (int j = 0; j < 2 * nw; j++) pay_q.push_back(8'($urandom_range(0, 255)));
         fpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * nw + 1)) : -1;
         bad  = ($urandom_range(0, 3) == 0);
         send_frame(fpos, bad);
         end_check("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
